// File: rtl/tape_player.sv
// Cassette-tape emulator: streams a byte file out of RAM as a 1200/2400-baud FSK signal,
// turning each 8-byte header block into a silence gap followed by a sync tone.
module tape_player #(
  parameter int ADDR_W     = 27,
  parameter int CE_HZ      = 5369318,
  parameter int LONG_BITS  = 8000,
  parameter int SHORT_BITS = 2000,
  parameter int GAP_BITS   = 1200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              play,
  input  logic              rewind,
  input  logic              turbo,
  input  logic [ADDR_W-1:0] data_len,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_rd,
  input  logic [7:0]        ram_di,
  input  logic              ram_ready,
  output logic              cas_out,
  output logic              playing,
  output logic              at_end,
  output logic [2:0]        state_dbg
);

  localparam int HALF      = CE_HZ / 4800;
  localparam int GAP_TICKS = GAP_BITS * 4 * HALF;
  localparam int TW        = $clog2(2 * HALF + 1);
  localparam logic [63:0] HEADER = 64'h1FA6_DEBA_CC13_7D74;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_GAP   = 3'd3,
    S_SYNC  = 3'd4,
    S_BYTE  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              rd_q, rd_d;
  logic              cas_q, cas_d;
  logic              long_q, long_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [1:0]        half_q, half_d;
  logic              cur_bit_q, cur_bit_d;
  logic              fast_q, fast_d;
  logic [63:0]       buf_q, buf_d;

  logic              adv;
  logic [ADDR_W-1:0] rem;
  logic [3:0]        n_bytes;
  logic              is_hdr;
  logic [7:0]        cur_byte;
  logic              nxt_bit;
  logic [TW-1:0]     hp_len;
  logic              half_done;
  logic              last_half;
  logic [31:0]       sync_bits;
  logic              load_bit;
  logic              load_val;

  // Byte i of the block sits at buf_q[63-8i -: 8], so the header compares as one literal.
  assign adv       = ce & play;
  assign rem       = data_len - ptr_q;
  assign n_bytes   = (ptr_q >= data_len) ? 4'd0 :
                     (rem >= ADDR_W'(8)) ? 4'd8 : rem[3:0];
  assign is_hdr    = (n_bytes == 4'd8) && (ptr_q[2:0] == 3'd0) && (buf_q == HEADER);
  assign cur_byte  = buf_q[{~idx_q[2:0], 3'b000} +: 8];
  assign nxt_bit   = (bit_cnt_q <= 4'd7) ? cur_byte[bit_cnt_q[2:0]] : 1'b1;
  assign sync_bits = long_q ? 32'(LONG_BITS) : 32'(SHORT_BITS);

  always_comb begin
    hp_len = cur_bit_q ? TW'(HALF) : TW'(2 * HALF);
    if (fast_q) hp_len = hp_len >> 1;
  end

  assign half_done = (tick_q == hp_len - TW'(1));
  assign last_half = cur_bit_q ? (half_q == 2'd3) : (half_q == 2'd1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    rd_d      = rd_q;
    cas_d     = cas_q;
    long_d    = long_q;
    idx_d     = idx_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    tick_d    = tick_q;
    half_d    = half_q;
    cur_bit_d = cur_bit_q;
    fast_d    = fast_q;
    buf_d     = buf_q;
    load_bit  = 1'b0;
    load_val  = 1'b0;

    if (rewind) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      a_d     = '0;
      rd_d    = 1'b0;
      cas_d   = 1'b0;
      long_d  = 1'b1;
      idx_d   = 4'd0;
      cnt_d   = 32'd0;
      tick_d  = '0;
      half_d  = 2'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (adv) begin
            idx_d   = 4'd0;
            state_d = (ptr_q < data_len) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: begin
          // A read already in flight completes even while paused.
          if (rd_q) begin
            if (ram_ready) begin
              buf_d[{~idx_q[2:0], 3'b000} +: 8] = ram_di;
              idx_d = idx_q + 4'd1;
              rd_d  = 1'b0;
            end
          end else if (adv) begin
            if (idx_q == n_bytes) begin
              state_d = S_CHECK;
            end else begin
              rd_d = 1'b1;
              a_d  = ptr_q + ADDR_W'(idx_q);
            end
          end
        end
        S_CHECK: begin
          if (adv) begin
            if (n_bytes == 4'd0) begin
              state_d = S_IDLE;
            end else if (is_hdr) begin
              state_d = S_GAP;
              cnt_d   = 32'd0;
            end else begin
              state_d   = S_BYTE;
              idx_d     = 4'd0;
              bit_cnt_d = 4'd0;
              load_bit  = 1'b1;
              load_val  = 1'b0;
            end
          end
        end
        S_GAP: begin
          if (adv) begin
            if (cnt_q == 32'(GAP_TICKS - 1)) begin
              state_d  = S_SYNC;
              cnt_d    = 32'd0;
              load_bit = 1'b1;
              load_val = 1'b1;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        S_SYNC, S_BYTE: begin
          if (adv) begin
            if (!half_done) begin
              tick_d = tick_q + TW'(1);
            end else if (!last_half) begin
              cas_d  = ~cas_q;
              half_d = half_q + 2'd1;
              tick_d = '0;
            end else if (state_q == S_SYNC) begin
              if (cnt_q == sync_bits - 32'd1) begin
                ptr_d   = ptr_q + ADDR_W'(8);
                long_d  = ~long_q;
                state_d = S_FETCH;
                idx_d   = 4'd0;
                cas_d   = 1'b0;
              end else begin
                cnt_d    = cnt_q + 32'd1;
                load_bit = 1'b1;
                load_val = 1'b1;
              end
            end else if (bit_cnt_q == 4'd10) begin
              if (idx_q == n_bytes - 4'd1) begin
                ptr_d   = ptr_q + ADDR_W'(n_bytes);
                state_d = S_IDLE;
                cas_d   = 1'b0;
              end else begin
                idx_d     = idx_q + 4'd1;
                bit_cnt_d = 4'd0;
                load_bit  = 1'b1;
                load_val  = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              load_bit  = 1'b1;
              load_val  = nxt_bit;
            end
          end
        end
        S_DONE: begin
          cas_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Every bit starts high; turbo is latched here so it only changes on bit boundaries.
    if (load_bit) begin
      cas_d     = 1'b1;
      tick_d    = '0;
      half_d    = 2'd0;
      cur_bit_d = load_val;
      fast_d    = turbo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      a_q       <= '0;
      rd_q      <= 1'b0;
      cas_q     <= 1'b0;
      long_q    <= 1'b1;
      idx_q     <= 4'd0;
      bit_cnt_q <= 4'd0;
      cnt_q     <= 32'd0;
      tick_q    <= '0;
      half_q    <= 2'd0;
      cur_bit_q <= 1'b0;
      fast_q    <= 1'b0;
      buf_q     <= 64'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      rd_q      <= rd_d;
      cas_q     <= cas_d;
      long_q    <= long_d;
      idx_q     <= idx_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      half_q    <= half_d;
      cur_bit_q <= cur_bit_d;
      fast_q    <= fast_d;
      buf_q     <= buf_d;
    end
  end

  assign ram_a     = a_q;
  assign ram_rd    = rd_q;
  assign cas_out   = cas_q & play;
  assign playing   = play & (state_q != S_IDLE) & (state_q != S_DONE);
  assign at_end    = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: doc/tape_player.md
TAPE_PLAYER -- requirements
Module: tape_player

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, buffer address width.
REQ-002 SHALL have parameter CE_HZ, default 5369318, ce rate; HALF = CE_HZ/4800 (integer division), ce ticks per half-period of 2400 Hz.
REQ-003 SHALL have parameters LONG_BITS (8000), SHORT_BITS (2000) and GAP_BITS (1200): sync-tone and pre-header-silence lengths, counted in bit periods.
REQ-004 SHALL have ports:
- clk  in  1  system clock; all logic in this single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  tick enable; timing advances only on ce.
- play  in  1  high = run, low = pause.
- rewind  in  1  synchronous rewind request.
- turbo  in  1  0 = 1200 baud, 1 = 2400 baud; all half-periods halved.
- data_len  in  ADDR_W  file length in bytes.
- ram_a  out  ADDR_W  byte address.
- ram_rd  out  1  read request.
- ram_di  in  8  read data.
- ram_ready  in  1  read complete.
- cas_out  out  1  FSK tape signal.
- playing  out  1  high when not IDLE/DONE and play = 1.
- at_end  out  1  high in DONE.

Function
REQ-005 SHALL implement states IDLE, FETCH, CHECK, GAP, SYNC, BYTE and DONE.
REQ-006 IDLE: when play = 1 and ptr < data_len, SHALL enter FETCH; when ptr >= data_len, SHALL enter DONE.
REQ-007 FETCH SHALL read N = min(8, data_len - ptr) bytes at ptr..ptr+N-1 into an 8-entry buffer.
REQ-008 Read handshake: ram_a SHALL be stable while ram_rd is high; ram_rd SHALL stay high until ram_ready = 1; data SHALL be captured in the cycle where ram_rd and ram_ready are both high; ram_rd SHALL drop the next cycle.
REQ-009 CHECK: N = 8, ptr%8 = 0 and buffer = 1F A6 DE BA CC 13 7D 74 is a header; on a header SHALL skip the 8 buffer bytes and enter GAP; otherwise SHALL enter BYTE with the N buffered bytes.
REQ-010 GAP SHALL hold cas_out = 0 for GAP_BITS*4*HALF ce ticks, then enter SYNC.
REQ-011 SYNC SHALL emit LONG_BITS '1' bits on the first header after reset/rewind and SHORT_BITS/LONG_BITS alternately thereafter, then advance ptr by 8 and enter FETCH.
REQ-012 Bit encoding: '1' = four half-periods of HALF ticks; '0' = two half-periods of 2*HALF ticks; cas_out SHALL toggle at each half-period boundary and SHALL start each bit high.
REQ-013 BYTE frame: one '0' start bit, 8 data bits LSB first, two '1' stop bits (11 bits).
REQ-014 After the last buffered byte, BYTE SHALL add N to ptr and return to IDLE.
REQ-015 Pause (play = 0) SHALL freeze all counters and state and force cas_out = 0; outstanding reads SHALL still complete; resuming SHALL continue from the exact tick.
REQ-016 turbo SHALL be sampled only at bit boundaries.
REQ-017 rewind SHALL take priority over play and all states: ptr = 0, state IDLE, ram_rd = 0, cas_out = 0, next header long; a mid-read ram_ready SHALL be ignored.
REQ-018 DONE SHALL hold cas_out = 0 and at_end = 1 until rewind.
REQ-019 ptr SHALL be ADDR_W bits; data_len = 0 SHALL reach DONE without issuing reads.

Reset
REQ-020 reset_n = 0 SHALL asynchronously force: state IDLE, ptr 0, ram_a 0, ram_rd 0, cas_out 0, playing 0, at_end 0, long-header flag set.

Verification (CE_HZ=48000 so HALF=10; LONG_BITS=4, SHORT_BITS=2, GAP_BITS=2; ce every cycle; ram_ready 2 cycles after ram_rd)
REQ-021 Data byte 0x01, data_len 1, play -> cas_out bits 0,1,0,0,0,0,0,0,0,1,1: edges every 20 ticks for '0' bits and every 10 ticks for '1' bits; then at_end = 1.
REQ-022 8-byte header then 0x00, data_len 9 -> 80 ticks of cas_out = 0, 4 '1' bits (160 ticks), then frame of 0x00; exactly 9 ram_rd pulses at addresses 0..8.
REQ-023 Two consecutive headers -> sync lengths 4 bits then 2 bits; after rewind the next sync is 4 bits.
REQ-024 play deasserted mid-bit for 37 cycles -> cas_out 0 during the pause; edge timing resumes with the remaining tick count; total bit length grows by exactly 37.
REQ-025 turbo = 1 with byte 0x01 -> all half-periods halved (5/10 ticks); rewind asserted mid-FETCH -> ram_rd low next cycle, ram_a 0, state IDLE.
REQ-026 reset_n pulsed low mid-BYTE -> all outputs at REQ-020 values immediately, without a clock edge.
